// File: rtl/hog_pkg.sv
// Shared types and widths for the HOG front end: pixel/word widths and feeder FSM states.
package hog_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned IN_W  = 4 * PIX_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/word_fifo.sv
// Synchronous word FIFO with registered read data (no fall-through) and a flush.
module word_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push_c;
  logic          do_pop_c;
  logic [CW-1:0] count_nxt_c;

  // Flush has priority; full/empty guard against overrun and underrun.
  always_comb begin
    do_push_c   = push && !flush && !full;
    do_pop_c    = pop && !flush && !empty;
    count_nxt_c = flush ? '0 : count + CW'(do_push_c) - CW'(do_pop_c);
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      dout   <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_pop_c) dout <= mem[rd_ptr];
      count <= count_nxt_c;
      full  <= (count_nxt_c == CW'(DEPTH));
      empty <= (count_nxt_c == '0);
    end
  end

endmodule

// File: rtl/pixel_feeder.sv
// Packs camera pixels four to a word, buffers them, and hands one word per request downstream.
module pixel_feeder #(
  parameter int unsigned PIX_W      = hog_pkg::PIX_W,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FRAME_PIX  = 19200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 pix_valid,
  input  logic [PIX_W-1:0]     pix_data,
  output logic                 pix_ready,
  input  logic                 request,
  output logic                 ready,
  output logic [4*PIX_W-1:0]   i_data,
  output logic                 frame_done,
  output logic                 ovf_err,
  output logic                 abort_err
);

  import hog_pkg::*;

  localparam int unsigned WORD_W = 4 * PIX_W;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  feeder_state_e     state;
  feeder_state_e     state_nxt;
  logic [15:0]       pix_cnt;
  logic [1:0]        pack_idx;
  logic [WORD_W-1:0] pack_word;
  logic [WORD_W-1:0] word_c;
  logic              req_pend;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  fill_c;
  logic              fifo_full;
  logic              fifo_empty;
  logic              abort_c;
  logic              accept_c;
  logic              push_c;
  logic              pop_c;
  logic              last_pix_c;
  logic              last_word_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (frame_start) state_nxt = S_RUN;
      S_RUN:   if (frame_start) state_nxt = S_RUN;
               else if (last_pix_c) state_nxt = S_DRAIN;
      S_DRAIN: if (frame_start) state_nxt = S_RUN;
               else if (last_word_c) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath strobes; a frame_start mid-frame flushes everything and drops that cycle's pixel.
  always_comb begin
    abort_c     = frame_start && (state != S_IDLE);
    accept_c    = (state == S_RUN) && pix_valid && pix_ready && !frame_start
                  && !(fifo_full && (pack_idx == 2'd3));
    push_c      = accept_c && (pack_idx == 2'd3);
    last_pix_c  = accept_c && (pix_cnt == 16'(FRAME_PIX - 1));
    pop_c       = req_pend && !abort_c;
    last_word_c = (state == S_DRAIN) && pop_c && (fifo_count == CNT_W'(1));
    word_c      = {pix_data, pack_word[WORD_W-1:PIX_W]};
    fill_c      = abort_c ? '0 : fifo_count + CNT_W'(push_c);
  end

  // Pixels shift in from the top so pixel 0 ends up in the LSBs after four accepts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_ready  <= 1'b0;
      ready      <= 1'b0;
      frame_done <= 1'b0;
      ovf_err    <= 1'b0;
      abort_err  <= 1'b0;
      pix_cnt    <= '0;
      pack_idx   <= '0;
      pack_word  <= '0;
      req_pend   <= 1'b0;
    end else begin
      pix_ready  <= (state_nxt == S_RUN) && (fill_c < CNT_W'(FIFO_DEPTH));
      ready      <= pop_c;
      frame_done <= last_word_c;
      if (frame_start) begin
        pix_cnt   <= '0;
        pack_idx  <= '0;
        pack_word <= '0;
      end else if (accept_c) begin
        pix_cnt   <= pix_cnt + 16'd1;
        pack_idx  <= pack_idx + 2'd1;
        pack_word <= word_c;
      end
      if (frame_start && (state == S_IDLE)) begin
        ovf_err   <= 1'b0;
        abort_err <= 1'b0;
      end else begin
        if (abort_c) abort_err <= 1'b1;
        if ((state == S_RUN) && pix_valid && !pix_ready) ovf_err <= 1'b1;
      end
      // A request is only latched against a non-empty FIFO and while none is outstanding.
      if (abort_c || req_pend) req_pend <= 1'b0;
      else if (request && !fifo_empty) req_pend <= 1'b1;
    end
  end

  word_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort_c),
    .push  (push_c),
    .din   (word_c),
    .pop   (pop_c),
    .dout  (i_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: doc/pixel_feeder.md
PIXEL_FEEDER -- requirements
Module: pixel_feeder

Interface
REQ-001 Parameter PIX_W, default 8: pixel width in bits.
REQ-002 Parameter FIFO_DEPTH, default 8: word FIFO entries; power of two, at least 2.
REQ-003 Parameter FRAME_PIX, default 19200: pixels per frame; a multiple of 4.
REQ-004 Port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-low.
REQ-006 Port frame_start, input, 1: single-cycle pulse that starts a frame.
REQ-007 Port pix_valid, input, 1: the pixel on pix_data is offered this cycle.
REQ-008 Port pix_data, input, PIX_W: camera pixel.
REQ-009 Port pix_ready, output, 1: the block accepts a pixel this cycle.
REQ-010 Port request, input, 1: the downstream hog_to_svm stage asks for one 4-pixel word.
REQ-011 Port ready, output, 1: i_data holds a valid word this cycle.
REQ-012 Port i_data, output, 4*PIX_W: four packed pixels.
REQ-013 Port frame_done, output, 1: single-cycle pulse when the last word of a frame has been delivered.
REQ-014 Port ovf_err, output, 1: sticky flag; a pixel was offered while pix_ready=0 during S_RUN.
REQ-015 Port abort_err, output, 1: sticky flag; frame_start arrived while a frame was in progress.

Function
REQ-016 The FSM SHALL have three states, S_IDLE, S_RUN and S_DRAIN, with these transitions:
- S_IDLE to S_RUN on frame_start.
- S_RUN to S_DRAIN when pixel FRAME_PIX has been accepted.
- S_DRAIN to S_IDLE when the last word has been delivered, with frame_done pulsed in that same cycle.
REQ-017 pix_ready SHALL be 1 only in S_RUN when the FIFO count is below FIFO_DEPTH; it is registered from the count and ignores a pop in the same cycle.
REQ-018 An accepted pixel k of a word SHALL occupy i_data bits [PIX_W*(k+1)-1 : PIX_W*k], k=0..3; pixel 0 goes in the LSBs.
REQ-019 When the 4th pixel is accepted, the packed word SHALL be pushed into the FIFO on the same edge.
REQ-020 The pixel counter SHALL be 16 bits wide; it clears on frame_start and increments on each accepted pixel.
REQ-021 Pixels offered in S_IDLE or S_DRAIN SHALL be dropped without setting ovf_err.
REQ-022 If request=1 and the FIFO is non-empty at edge N, then after edge N+1:
- ready=1 for exactly one cycle;
- i_data holds the FIFO head word;
- the head has been popped.
REQ-023 After each delivered word, ready SHALL be 0 for at least one cycle; at most one word is delivered per two cycles.
REQ-024 If request=1 and the FIFO is empty, the block SHALL wait; ready stays 0 and no request state is latched.
REQ-025 When ready=0, i_data SHALL hold its last value.
REQ-026 A push and a pop in the same cycle SHALL leave the FIFO count unchanged.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 frame_start in S_RUN or S_DRAIN SHALL:
- set abort_err;
- flush the FIFO and the partial word;
- clear the counter;
- enter S_RUN.
No frame_done is produced for the aborted frame.
REQ-029 frame_start in S_IDLE SHALL clear ovf_err and abort_err.

Reset
REQ-030 While rst=0, the block SHALL be in S_IDLE with:
- FIFO empty, pointers, counter and packing index at 0;
- pix_ready, ready, frame_done, ovf_err and abort_err at 0;
- i_data at 0.
REQ-031 Reset deassertion SHALL take effect on the next rising clk edge; an assertion mid-frame discards all buffered data.

Structure
REQ-032 The shared package hog_pkg SHALL hold:
- PIX_W;
- IN_W = 4*PIX_W;
- the feeder state enum type.
REQ-033 The FIFO SHALL be the sub-module word_fifo, parameterised by width and depth; it has push, pop, full, empty and count ports and no first-word fall-through.

Verification
REQ-034 Reset, frame_start, then pixels 0x01..0x04 with request held at 1 -> one ready pulse with i_data=0x04030201.
REQ-035 FIFO_DEPTH=8, request=0, 36 pixels offered continuously -> pix_ready drops after 32 pixels and ovf_err=1; FRAME_PIX/4 requests later, the count read back is 8 words.
REQ-036 FRAME_PIX=16, request always 1 -> 4 words are delivered, frame_done pulses once in the cycle of the 4th ready, and the state returns to S_IDLE.
REQ-037 frame_start after 6 pixels of a frame -> abort_err=1, FIFO empty, and the next word equals pixels 0..3 of the new frame.
REQ-038 rst=0 asynchronously with 3 words buffered -> all outputs are 0 immediately, and no ready occurs after release until a new frame_start and new pixels arrive.
